// File: rtl/wash_run_pkg.sv
// Shared definitions for the wash_run execution stage: state encoding, price and
// duration tables (BCD, indexed by mode), display codes and phase LED patterns.
package wash_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_WASH,
    S_RINSE,
    S_SPIN,
    S_PAUSED,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] MINUS_CODE = 4'd10;

  localparam logic [2:0] PH_NONE  = 3'b000;
  localparam logic [2:0] PH_WASH  = 3'b001;
  localparam logic [2:0] PH_RINSE = 3'b010;
  localparam logic [2:0] PH_SPIN  = 3'b100;

  // Tables are packed with mode 0 in the lowest slot, so TBL[mode] indexes directly.
  localparam logic [3:0][11:0] PRICE_TBL = {12'h012, 12'h008, 12'h005, 12'h003};
  localparam logic [3:0][3:0]  PRICE_CYC = {4'd12, 4'd8, 4'd5, 4'd3};
  localparam logic [3:0][11:0] WASH_TBL  = {12'h060, 12'h040, 12'h030, 12'h020};
  localparam logic [3:0][11:0] RINSE_TBL = {12'h040, 12'h030, 12'h020, 12'h010};
  localparam logic [3:0][11:0] SPIN_TBL  = {12'h030, 12'h020, 12'h010, 12'h010};
  localparam logic [3:0][11:0] TOTAL_TBL = {12'h130, 12'h090, 12'h060, 12'h040};

  function automatic logic [3:0] phase_digit(input state_t s);
    case (s)
      S_WASH:  return 4'd1;
      S_RINSE: return 4'd2;
      S_SPIN:  return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] phase_onehot(input state_t s);
    case (s)
      S_WASH:  return PH_WASH;
      S_RINSE: return PH_RINSE;
      S_SPIN:  return PH_SPIN;
      default: return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wash_run_bcd3_dec.sv
// Three-digit BCD decrement by one, saturating at 000. Input assumed valid BCD.
module wash_run_bcd3_dec (
  input  logic [11:0] val,
  output logic [11:0] dec
);

  always_comb begin
    dec = val;
    if (val != 12'h000) begin
      if (val[3:0] != 4'd0) begin
        dec[3:0] = val[3:0] - 4'd1;
      end else begin
        dec[3:0] = 4'd9;
        if (val[7:4] != 4'd0) begin
          dec[7:4] = val[7:4] - 4'd1;
        end else begin
          dec[7:4]  = 4'd9;
          dec[11:8] = val[11:8] - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/wash_run.sv
// Washing machine execution stage: charges the mode price, then runs WASH/RINSE/SPIN
// with a BCD seconds countdown. Optional completion beep under WASH_RUN_BEEP_EN.
module wash_run
  import wash_run_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic [1:0]  mode,
  input  logic [11:0] bal_in,
  output logic [11:0] bal_out,
  output logic [3:0]  d3,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic [2:0]  phase,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef WASH_RUN_BEEP_EN
  ,
  output logic        beep
`endif
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t          state, state_n;
  state_t          saved, saved_n;
  logic [1:0]      mode_q, mode_n;
  logic [11:0]     bal_n, rem_q, rem_n, tmr_q, tmr_n;
  logic [11:0]     bal_dec, rem_dec, tmr_dec;
  logic [TW-1:0]   tick_q, tick_n;
  logic [3:0]      cnt_q, cnt_n;
  logic            tick_end;
  logic [11:0]     disp_n;
  logic [3:0]      d0_n;
  logic [2:0]      phase_n;
  logic            busy_n, done_n, err_n;
`ifdef WASH_RUN_BEEP_EN
  logic            beep_n;
  logic [1:0]      bticks_q, bticks_n;
`endif

  wash_run_bcd3_dec u_bal_dec (.val(bal_out), .dec(bal_dec));
  wash_run_bcd3_dec u_rem_dec (.val(rem_q),   .dec(rem_dec));
  wash_run_bcd3_dec u_tmr_dec (.val(tmr_q),   .dec(tmr_dec));

  assign tick_end = (tick_q == TICK_LAST);

  always_comb begin
    state_n = state;
    saved_n = saved;
    mode_n  = mode_q;
    bal_n   = bal_out;
    rem_n   = rem_q;
    tmr_n   = tmr_q;
    tick_n  = tick_q;
    cnt_n   = cnt_q;
`ifdef WASH_RUN_BEEP_EN
    beep_n   = beep;
    bticks_n = bticks_q;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          mode_n = mode;
          if (bal_in >= PRICE_TBL[mode]) begin
            bal_n   = bal_in;
            cnt_n   = PRICE_CYC[mode];
            state_n = S_CHARGE;
          end else begin
            state_n = S_ERR;
          end
        end
      end

      S_CHARGE: begin
        bal_n = bal_dec;
        cnt_n = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rem_n   = TOTAL_TBL[mode_q];
          tmr_n   = WASH_TBL[mode_q];
          tick_n  = '0;
          state_n = S_WASH;
        end
      end

      S_WASH, S_RINSE, S_SPIN: begin
        if (tick_end) begin
          tick_n = '0;
          rem_n  = rem_dec;
          tmr_n  = tmr_dec;
          if (tmr_dec == 12'h000) begin
            if (state == S_WASH) begin
              state_n = S_RINSE;
              tmr_n   = RINSE_TBL[mode_q];
            end else if (state == S_RINSE) begin
              state_n = S_SPIN;
              tmr_n   = SPIN_TBL[mode_q];
            end else begin
              state_n = S_DONE;
              rem_n   = 12'h000;
`ifdef WASH_RUN_BEEP_EN
              beep_n   = 1'b1;
              bticks_n = 2'd0;
`endif
            end
          end
        end else begin
          tick_n = tick_q + TW'(1);
        end
        // A coincident terminal tick is applied above before the pause takes effect.
        if (pause && state_n != S_DONE) begin
          saved_n = state_n;
          state_n = S_PAUSED;
        end
      end

      S_PAUSED: begin
        if (pause) state_n = saved;
      end

      S_DONE: begin
        if (start) begin
          state_n = S_IDLE;
`ifdef WASH_RUN_BEEP_EN
          beep_n  = 1'b0;
        end else if (beep) begin
          if (tick_end) begin
            tick_n   = '0;
            bticks_n = bticks_q + 2'd1;
            if (bticks_q == 2'd2) beep_n = 1'b0;
          end else begin
            tick_n = tick_q + TW'(1);
          end
`endif
        end
      end

      S_ERR: begin
        if (start) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    // Display and status are derived from next-state values so they register in step.
    disp_n  = bal_n;
    d0_n    = 4'd0;
    phase_n = PH_NONE;
    case (state_n)
      S_WASH, S_RINSE, S_SPIN: begin
        disp_n  = rem_n;
        d0_n    = phase_digit(state_n);
        phase_n = phase_onehot(state_n);
      end
      S_PAUSED: begin
        disp_n = rem_n;
        d0_n   = phase_digit(saved_n);
      end
      S_DONE: disp_n = 12'h000;
      S_ERR: begin
        disp_n = {MINUS_CODE, MINUS_CODE, MINUS_CODE};
        d0_n   = MINUS_CODE;
      end
      default: ;
    endcase
    busy_n = (state_n == S_CHARGE) || (state_n == S_WASH) || (state_n == S_RINSE) ||
             (state_n == S_SPIN) || (state_n == S_PAUSED);
    done_n = (state_n == S_DONE);
    err_n  = (state_n == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      saved   <= S_IDLE;
      mode_q  <= 2'd0;
      bal_out <= 12'h000;
      rem_q   <= 12'h000;
      tmr_q   <= 12'h000;
      tick_q  <= '0;
      cnt_q   <= 4'd0;
      d3      <= 4'd0;
      d2      <= 4'd0;
      d1      <= 4'd0;
      d0      <= 4'd0;
      phase   <= PH_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef WASH_RUN_BEEP_EN
      beep     <= 1'b0;
      bticks_q <= 2'd0;
`endif
    end else begin
      state   <= state_n;
      saved   <= saved_n;
      mode_q  <= mode_n;
      bal_out <= bal_n;
      rem_q   <= rem_n;
      tmr_q   <= tmr_n;
      tick_q  <= tick_n;
      cnt_q   <= cnt_n;
      d3      <= disp_n[11:8];
      d2      <= disp_n[7:4];
      d1      <= disp_n[3:0];
      d0      <= d0_n;
      phase   <= phase_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
`ifdef WASH_RUN_BEEP_EN
      beep     <= beep_n;
      bticks_q <= bticks_n;
`endif
    end
  end

endmodule

// File: tb/tb_wash_run.sv
// Self-checking bench for wash_run: directed scenarios plus randomized runs, every
// cycle compared against a seconds-level integer model of the machine.
module tb_wash_run;

  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst, start, pause;
  logic [1:0]  mode;
  logic [11:0] bal_in, bal_out;
  logic [3:0]  d3, d2, d1, d0;
  logic [2:0]  phase;
  logic        busy, done, err;
`ifdef WASH_RUN_BEEP_EN
  logic        beep;
`endif
  logic [33:0] dut_vec;

  wash_run #(.TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mode(mode), .bal_in(bal_in),
    .bal_out(bal_out), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .phase(phase),
    .busy(busy), .done(done), .err(err)
`ifdef WASH_RUN_BEEP_EN
    , .beep(beep)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  assign dut_vec = {bal_out, d3, d2, d1, d0, phase, busy, done, err};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: whole seconds and integer balances
  typedef enum int {M_IDLE, M_CHARGE, M_RUN, M_PAUSED, M_DONE, M_ERR} mstate_t;
  mstate_t m_st;
  int m_bal, m_rem, m_tmr, m_tick, m_left, m_ph, m_mode, m_beep;
  int price [4]   = '{3, 5, 8, 12};
  int dur   [4][3] = '{'{20, 10, 10}, '{30, 20, 10}, '{40, 30, 20}, '{60, 40, 30}};
  int bal_int;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_bal = 0; m_rem = 0; m_tmr = 0; m_tick = 0;
    m_left = 0; m_ph = 0; m_mode = 0; m_beep = 0;
  endtask

  task automatic model_step(input logic s, input logic p, input int md, input int bin);
    case (m_st)
      M_IDLE: if (s) begin
        m_mode = md;
        if (bin >= price[md]) begin
          m_bal = bin; m_left = price[md]; m_st = M_CHARGE;
        end else m_st = M_ERR;
      end
      M_CHARGE: begin
        m_bal--; m_left--;
        if (m_left == 0) begin
          m_rem = dur[m_mode][0] + dur[m_mode][1] + dur[m_mode][2];
          m_ph = 0; m_tmr = dur[m_mode][0]; m_tick = 0; m_st = M_RUN;
        end
      end
      M_RUN: begin
        m_tick++;
        if (m_tick == TICK) begin
          m_tick = 0;
          if (m_rem > 0) m_rem--;
          m_tmr--;
          if (m_tmr == 0) begin
            m_ph++;
            if (m_ph == 3) begin
              m_st = M_DONE; m_rem = 0; m_beep = 3 * TICK;
            end else m_tmr = dur[m_mode][m_ph];
          end
        end
        if (p && m_st == M_RUN) m_st = M_PAUSED;
      end
      M_PAUSED: if (p) m_st = M_RUN;
      M_DONE: begin
        if (s) begin m_st = M_IDLE; m_beep = 0; end
        else if (m_beep > 0) m_beep--;
      end
      M_ERR: if (s) m_st = M_IDLE;
      default: m_st = M_IDLE;
    endcase
  endtask

  function automatic logic [33:0] model_out();
    logic [11:0] disp;
    logic [3:0]  dd0;
    logic [2:0]  ph;
    disp = to_bcd(m_bal); dd0 = 4'd0; ph = 3'b000;
    case (m_st)
      M_RUN:    begin disp = to_bcd(m_rem); dd0 = 4'(m_ph + 1); ph = 3'(1 << m_ph); end
      M_PAUSED: begin disp = to_bcd(m_rem); dd0 = 4'(m_ph + 1); end
      M_DONE:   disp = 12'h000;
      M_ERR:    begin disp = 12'haaa; dd0 = 4'ha; end
      default: ;
    endcase
    return {to_bcd(m_bal), disp, dd0, ph, (m_st == M_CHARGE || m_st == M_RUN || m_st == M_PAUSED),
            (m_st == M_DONE), (m_st == M_ERR)};
  endfunction

  task automatic compare_all(input string tag);
    check(tag, dut_vec, model_out());
`ifdef WASH_RUN_BEEP_EN
    check({tag, "_beep"}, beep, (m_st == M_DONE && m_beep > 0));
`endif
  endtask

  // driver tasks
  task automatic set_bal(input int v);
    bal_int = v;
    bal_in  = to_bcd(v);
  endtask

  task automatic step(input logic s, input logic p);
    start = s; pause = p;
    @(posedge clk);
    model_step(s, p, int'(mode), bal_int);
    #1;
    start = 1'b0; pause = 1'b0;
    compare_all("cycle");
  endtask

  task automatic run_to_end(input int budget, input int pause_pct, input int start_pct);
    int n = 0;
    while (!(m_st == M_DONE || m_st == M_ERR) && n < budget) begin
      mode = 2'($urandom_range(0, 3));
      set_bal($urandom_range(0, 999));
      step($urandom_range(0, 99) < start_pct, $urandom_range(0, 99) < pause_pct);
      n++;
    end
    check("run_bound", n < budget, 1'b1);
  endtask

  task automatic step_until_tick(input int want_tick, input int want_rem);
    int n = 0;
    while (!(m_st == M_RUN && m_tick == want_tick && (want_rem < 0 || m_rem == want_rem)) && n < 400) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("seek_bound", n < 400, 1'b1);
  endtask

  initial begin
    int cnt, k, rem_before, prev_ph;
    logic [11:0] disp_before;
    rst = 1'b0; start = 1'b0; pause = 1'b0; mode = 2'd0; set_bal(0);
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1);

    // mode 1 from 050: charge, first tick, pause hold, resume, pause on terminal tick
    mode = 2'd1; set_bal(50);
    step(1'b1, 1'b0);
    mode = 2'd3; set_bal(999);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("charge_bal", bal_out, 12'h045);
    check("wash_start", {d3, d2, d1, d0, phase}, {12'h060, 4'd1, 3'b001});
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("first_tick", {d3, d2, d1, d0, phase}, {12'h059, 4'd1, 3'b001});
    step_until_tick(1, 55);
    step(1'b0, 1'b1);
    k = m_tick;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
    check("pause_hold", {d3, d2, d1, phase, busy}, {12'h055, 3'b000, 1'b1});
    step(1'b0, 1'b1);
    disp_before = {d3, d2, d1};
    cnt = 0;
    while ({d3, d2, d1} == disp_before && cnt < 20) begin step(1'b0, 1'b0); cnt++; end
    check("resume_latency", cnt, TICK - k);
    check("resume_value", {d3, d2, d1}, 12'h054);
    step_until_tick(TICK - 1, -1);
    rem_before = m_rem;
    step(1'b0, 1'b1);
    check("pause_terminal", {d3, d2, d1, phase, busy}, {to_bcd(rem_before - 1), 3'b000, 1'b1});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    run_to_end(2000, 0, 0);
`ifdef WASH_RUN_BEEP_EN
    cnt = beep ? 1 : 0;
    for (int i = 0; i < 19; i++) begin step(1'b0, 1'b0); if (beep) cnt++; end
    check("beep_len", cnt, 12);
`else
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
`endif
    step(1'b1, 1'b0);

    // mode 0 from 100: phase boundaries and total latency
    mode = 2'd0; set_bal(100);
    step(1'b1, 1'b0);
    cnt = 1; prev_ph = 0;
    while (!done && cnt < 400) begin
      step(1'b0, 1'b0);
      cnt++;
      if (m_st == M_RUN && m_ph != prev_ph) begin
        check($sformatf("phase_%0d_rem", m_ph), {d3, d2, d1}, (m_ph == 1) ? 12'h020 : 12'h010);
        prev_ph = m_ph;
      end
    end
    check("done_latency", cnt, 1 + 3 + 40 * TICK);
`ifdef WASH_RUN_BEEP_EN
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("beep_cancel", beep, 1'b0);
`else
    step(1'b1, 1'b0);
`endif
    check("bal_retained", {bal_out, done, busy}, {12'h097, 1'b0, 1'b0});

    // insufficient balance
    mode = 2'd2; set_bal(7);
    step(1'b1, 1'b0);
    check("err_state", {err, d3, d2, d1, d0, bal_out}, {1'b1, 16'haaaa, 12'h097});
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("err_exit", {err, busy, d3, d2, d1}, {1'b0, 1'b0, 12'h097});

    // asynchronous reset during RINSE
    mode = 2'd0; set_bal(500);
    step(1'b1, 1'b0);
    cnt = 0;
    while (!(m_st == M_RUN && m_ph == 1 && m_rem == 15) && cnt < 400) begin step(1'b0, 1'b0); cnt++; end
    check("rinse_reached", phase, 3'b010);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // randomized runs with stray pauses/starts and changing mode/bal_in
    for (int r = 0; r < 6; r++) begin
      mode = 2'($urandom_range(0, 3));
      set_bal(($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : $urandom_range(12, 999));
      step(1'b1, 1'b0);
      run_to_end(6000, 6, 3);
      for (int i = 0; i < $urandom_range(1, 16); i++) step(1'b0, $urandom_range(0, 3) == 0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_run.md
Name: wash_run

Overview:
- Execution stage of the washing machine; consumes the balance digits and mode handed off by the front-panel entry stage on its confirm pulse.
- Charges the mode price, then sequences WASH, RINSE and SPIN while counting remaining seconds down in BCD.
- Drives four display digits back to the shared 4-digit scanner and one-hot phase LEDs.

Parameters:
- TICK_DIV, 100000000: clock cycles per 1 s tick; the bench uses 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle debounced confirm pulse
- pause  in  1  single-cycle debounced pause/resume pulse
- mode  in  2  program select, 0..3
- bal_in  in  12  balance as 3 BCD digits {hundreds,tens,units}, 000-999
- bal_out  out  12  balance after charge, BCD
- d3,d2,d1  out  4 each  display digits, hundreds..units, BCD
- d0  out  4  phase/status digit; 4'd10 = '-'
- phase  out  3  one-hot {SPIN,RINSE,WASH}; 0 when not running
- busy  out  1  high in CHARGE/WASH/RINSE/SPIN/PAUSED
- done  out  1  high in DONE
- err  out  1  high in ERR

Behaviour:
- Reset (rst=0, async): state IDLE; bal_out=000; remaining=000; tick counter=0; all digits 0; phase=0; busy/done/err=0.
- Price/duration table (s): mode0 3/20,10,10; mode1 5/30,20,10; mode2 8/40,30,20; mode3 12/60,40,30.
- IDLE:
  - Displays bal_out on d3..d1; d0=0.
  - On start: latch mode and bal_in.
  - If bal_in >= price (plain 12-bit compare; valid for BCD): go to CHARGE. Otherwise go to ERR.
- CHARGE:
  - Decrements bal_out by one BCD unit per clock, borrowing across digits, for exactly price cycles.
  - Then loads remaining = wash+rinse+spin (BCD), loads the phase timer with the wash duration, clears the tick counter and enters WASH.
- WASH, RINSE, SPIN:
  - Tick counter counts 0..TICK_DIV-1.
  - At terminal count, remaining and the phase timer each decrement by 1 (BCD, borrow, no wrap below 000).
  - When the phase timer reaches 0 at a tick: WASH->RINSE or RINSE->SPIN, reloading the phase timer; SPIN->DONE.
  - Display: d3..d1 = remaining; d0 = 1/2/3 for WASH/RINSE/SPIN; phase one-hot matches.
- PAUSED:
  - A pause pulse in any running state enters PAUSED. The tick counter, remaining and the phase timer are frozen; the display holds its values; phase=0.
  - The next pause pulse resumes the saved phase with the tick counter unchanged.
  - If pause and the terminal tick coincide, the decrement happens first, then the block pauses.
- DONE:
  - done=1, remaining=000, d0=0.
  - start returns to IDLE; bal_out is retained.
- ERR:
  - err=1; d3..d0 all 4'd10; bal_out unchanged.
  - start returns to IDLE.
- Ignored events:
  - start in CHARGE, running states or PAUSED.
  - pause in IDLE, CHARGE, DONE or ERR.
- mode is sampled only at start.
- Reset mid-operation aborts immediately. The charged balance is not refunded: bal_out returns to 000.

Optional Feature:
- Macro: WASH_RUN_BEEP_EN.
- Defined:
  - Adds output port beep (1 bit).
  - beep is high for the first 3 ticks in DONE, using the same tick counter, then stays low. It also clears on start or reset.
- Undefined:
  - No beep port.
  - The DONE tick counter is not used.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, CHARGE, WASH, RINSE, SPIN, PAUSED, DONE, ERR);
  - MINUS_CODE=4'd10;
  - price and duration lookup constants indexed by mode;
  - phase one-hot constants.
- One natural sub-module: bcd3_dec, a 3-digit BCD decrement-by-one with saturation at 000.
  - Instantiated three times: balance, remaining, phase timer.

Test Plan:
- TICK_DIV=4, bal_in=12'h050, mode=1, start -> CHARGE lasts 5 cycles; bal_out=12'h045. Display shows 060, then 059 after 4 cycles, with d0=1 and phase=001.
- Run mode0 to completion -> WASH->RINSE when remaining=020; RINSE->SPIN when remaining=010; DONE with done=1 after 40 ticks plus 3 charge cycles. A second start returns to IDLE.
- bal_in=12'h007, mode=2 -> ERR: err=1, digits all 4'hA, bal_out unchanged. start -> IDLE.
- Pause pulse mid-WASH at remaining=055 -> display stays 055 for 100 cycles, phase=0. A resume pulse -> decrement resumes after the remaining partial tick.
- Pause on the terminal-tick cycle -> remaining decrements once, then freezes. rst low during RINSE -> all outputs 0 asynchronously; state IDLE after release.
- WASH_RUN_BEEP_EN defined -> beep high for exactly 12 cycles after entering DONE. Start during DONE beep -> beep drops the next cycle.
